// File: rtl/t03_request_unit_if.sv
// Shared single-port memory bus between the request unit (master) and memory (slave).
interface t03_request_unit_if;
    logic [31:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_busy;

    modport master (
        output bus_addr, bus_read, bus_write, bus_sel, bus_wdata,
        input  bus_rdata, bus_busy
    );

    modport slave (
        input  bus_addr, bus_read, bus_write, bus_sel, bus_wdata,
        output bus_rdata, bus_busy
    );
endinterface

// File: rtl/t03_request_unit.sv
// Sequential fetch / load / store sequencer for the single-cycle core; one bus
// transaction at a time, with byte lane steering for byte loads and stores.
module t03_request_unit (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic [31:0] pc,
    input  logic        read_mem,
    input  logic        write_mem,
    input  logic        load_byte,
    input  logic        store_byte,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] inst,
    output logic        i_hit,
    output logic        d_hit,
    output logic [31:0] data_read,
    t03_request_unit_if.master bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        FWAIT  = 3'd1,
        EXEC   = 3'd2,
        DATA   = 3'd3,
        DWAIT  = 3'd4,
        COMMIT = 3'd5
    } state_t;

    state_t      state;
    logic [4:0]  lane_shift;
    logic [31:0] load_steered;
    logic        is_load;
    logic        pc_lsb_unused;

    assign pc_lsb_unused = ^pc[1:0];
    assign lane_shift    = {data_addr[1:0], 3'b000};
    assign load_steered  = load_byte ? (bus.bus_rdata >> lane_shift) : bus.bus_rdata;
    assign is_load       = read_mem && !write_mem;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= FETCH;
            inst      <= '0;
            data_read <= '0;
        end else begin
            case (state)
                FETCH:  if (en) state <= FWAIT;
                FWAIT: begin
                    if (!bus.bus_busy) begin
                        inst  <= bus.bus_rdata;
                        state <= EXEC;
                    end
                end
                EXEC:   state <= (read_mem || write_mem) ? DATA : FETCH;
                DATA:   state <= DWAIT;
                DWAIT: begin
                    if (!bus.bus_busy) begin
                        if (is_load) data_read <= load_steered;
                        state <= COMMIT;
                    end
                end
                COMMIT: state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    // Bus and strobes decode from state; the fetch request is also gated by
    // nrst so an asserted reset silences the bus within the same cycle.
    always_comb begin
        bus.bus_addr  = '0;
        bus.bus_read  = 1'b0;
        bus.bus_write = 1'b0;
        bus.bus_sel   = '0;
        bus.bus_wdata = '0;
        i_hit         = 1'b0;
        d_hit         = 1'b0;
        case (state)
            FETCH, FWAIT: begin
                if (nrst && (en || state == FWAIT)) begin
                    bus.bus_read = 1'b1;
                    bus.bus_addr = {pc[31:2], 2'b00};
                    bus.bus_sel  = '1;
                end
            end
            EXEC: i_hit = !(read_mem || write_mem);
            DATA, DWAIT: begin
                bus.bus_addr = {data_addr[31:2], 2'b00};
                if (write_mem) begin
                    bus.bus_write = 1'b1;
                    if (store_byte) begin
                        bus.bus_sel   = 4'b0001 << data_addr[1:0];
                        bus.bus_wdata = {4{data_wdata[7:0]}};
                    end else begin
                        bus.bus_sel   = '1;
                        bus.bus_wdata = data_wdata;
                    end
                end else begin
                    bus.bus_read = 1'b1;
                    bus.bus_sel  = '1;
                end
            end
            COMMIT: begin
                i_hit = 1'b1;
                d_hit = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_t03_request_unit.sv
// Directed, table-driven bench for t03_request_unit with hand-computed expectations.
module tb_t03_request_unit;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic [31:0] pc;
    logic        read_mem, write_mem, load_byte, store_byte;
    logic [31:0] data_addr, data_wdata;
    logic [31:0] inst, data_read;
    logic        i_hit, d_hit;

    int n_cmp = 0;
    int n_bad = 0;

    t03_request_unit_if bus_if ();

    t03_request_unit dut (
        .clk        (clk),
        .nrst       (nrst),
        .en         (en),
        .pc         (pc),
        .read_mem   (read_mem),
        .write_mem  (write_mem),
        .load_byte  (load_byte),
        .store_byte (store_byte),
        .data_addr  (data_addr),
        .data_wdata (data_wdata),
        .inst       (inst),
        .i_hit      (i_hit),
        .d_hit      (d_hit),
        .data_read  (data_read),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rd, wr, lb, sb;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          fbusy;
        int          dbusy;
        logic [31:0] faddr;
        logic [31:0] e_baddr;
        logic        e_read, e_write;
        logic [3:0]  e_sel;
        logic [31:0] e_wdata;
        logic [31:0] e_dread;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle_bus(input string nm);
        chk({nm, "_read"},  {31'd0, bus_if.bus_read},  32'd0);
        chk({nm, "_write"}, {31'd0, bus_if.bus_write}, 32'd0);
        chk({nm, "_sel"},   {28'd0, bus_if.bus_sel},   32'd0);
        chk({nm, "_addr"},  bus_if.bus_addr,           32'd0);
    endtask

    // Steps one instruction cycle by cycle; cycle 1 is the FETCH cycle.
    task automatic run_vec(input vec_t v, input int drop_en_cyc);
        bit mem;
        int fb_end, d_start, d_end, hit;
        mem     = v.rd | v.wr;
        fb_end  = 2 + v.fbusy;
        d_start = fb_end + 2;
        d_end   = d_start + 1 + v.dbusy;
        hit     = mem ? d_end + 1 : fb_end + 1;
        pc = v.pc; read_mem = v.rd; write_mem = v.wr;
        load_byte = v.lb; store_byte = v.sb;
        data_addr = v.daddr; data_wdata = v.wdata;
        for (int c = 1; c <= hit; c++) begin
            if (c == drop_en_cyc) en = 1'b0;
            bus_if.bus_busy  = (c >= 2 && c < fb_end) || (mem && c > d_start && c < d_end);
            bus_if.bus_rdata = (c == fb_end) ? v.inst : ((mem && c == d_end) ? v.rdata : 32'hDEADBEEF);
            #1;
            chk("i_hit", {31'd0, i_hit}, {31'd0, c == hit});
            chk("d_hit", {31'd0, d_hit}, {31'd0, mem && c == hit});
            if (c <= fb_end) begin
                chk("f_read",  {31'd0, bus_if.bus_read},  32'd1);
                chk("f_write", {31'd0, bus_if.bus_write}, 32'd0);
                chk("f_addr",  bus_if.bus_addr,           v.faddr);
                chk("f_sel",   {28'd0, bus_if.bus_sel},   32'hF);
            end else if (mem && c >= d_start && c <= d_end) begin
                chk("d_addr",  bus_if.bus_addr,           v.e_baddr);
                chk("d_read",  {31'd0, bus_if.bus_read},  {31'd0, v.e_read});
                chk("d_write", {31'd0, bus_if.bus_write}, {31'd0, v.e_write});
                chk("d_sel",   {28'd0, bus_if.bus_sel},   {28'd0, v.e_sel});
                if (v.e_write) chk("d_wdata", bus_if.bus_wdata, v.e_wdata);
            end else begin
                chk_idle_bus("x");
            end
            if (c == hit) begin
                chk("inst",      inst,      v.inst);
                chk("data_read", data_read, v.e_dread);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        //          pc         inst          rd wr lb sb daddr        wdata         rdata        fb db faddr       baddr        rd wr sel   wdata         dread
        vecs[0] = '{32'h00, 32'h00700093, 0, 0, 0, 0, 32'h0000, 32'h00000000, 32'h00000000, 0, 0, 32'h00, 32'h0000, 0, 0, 4'h0, 32'h00000000, 32'h00000000};
        vecs[1] = '{32'h04, 32'h00000013, 0, 0, 0, 0, 32'h0000, 32'h00000000, 32'h00000000, 4, 0, 32'h04, 32'h0000, 0, 0, 4'h0, 32'h00000000, 32'h00000000};
        vecs[2] = '{32'h08, 32'h00210183, 1, 0, 1, 0, 32'h1002, 32'h00000000, 32'hAABBCCDD, 0, 0, 32'h08, 32'h1000, 1, 0, 4'hF, 32'h00000000, 32'h0000AABB};
        vecs[3] = '{32'h0C, 32'h001101A3, 0, 1, 0, 1, 32'h1003, 32'h12345678, 32'h00000000, 0, 0, 32'h0C, 32'h1000, 0, 1, 4'h8, 32'h78787878, 32'h0000AABB};
        vecs[4] = '{32'h10, 32'h00002083, 1, 0, 0, 0, 32'h2006, 32'h00000000, 32'hCAFEF00D, 0, 2, 32'h10, 32'h2004, 1, 0, 4'hF, 32'h00000000, 32'hCAFEF00D};
        vecs[5] = '{32'h14, 32'h00002023, 1, 1, 0, 0, 32'h3001, 32'hA5A55A5A, 32'h00000000, 1, 1, 32'h14, 32'h3000, 0, 1, 4'hF, 32'hA5A55A5A, 32'hCAFEF00D};
        vecs[6] = '{32'h1A, 32'h00300083, 1, 0, 1, 0, 32'h4003, 32'h00000000, 32'h11223344, 0, 0, 32'h18, 32'h4000, 1, 0, 4'hF, 32'h00000000, 32'h00000011};
        vecs[7] = '{32'h20, 32'h00000023, 0, 1, 0, 1, 32'h5000, 32'hFFFFFF9C, 32'h00000000, 0, 0, 32'h20, 32'h5000, 0, 1, 4'h1, 32'h9C9C9C9C, 32'h00000011};

        nrst = 1'b0; en = 1'b1; pc = '0;
        read_mem = 0; write_mem = 0; load_byte = 0; store_byte = 0;
        data_addr = '0; data_wdata = '0;
        bus_if.bus_busy = 1'b0; bus_if.bus_rdata = '0;
        #1;
        chk("rst_inst", inst, 32'd0);
        chk("rst_dread", data_read, 32'd0);
        chk("rst_hits", {30'd0, i_hit, d_hit}, 32'd0);
        chk_idle_bus("rst");
        @(negedge clk);
        nrst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], 0);

        // Reset asserted while a fetch is waiting on a busy slave.
        pc = 32'h40; bus_if.bus_busy = 1'b0;
        @(negedge clk);
        bus_if.bus_busy = 1'b1;
        #1;
        chk("fwait_read", {31'd0, bus_if.bus_read}, 32'd1);
        #1 nrst = 1'b0;
        #1;
        chk_idle_bus("midrst");
        chk("midrst_inst", inst, 32'd0);
        chk("midrst_dread", data_read, 32'd0);
        chk("midrst_hits", {30'd0, i_hit, d_hit}, 32'd0);
        @(negedge clk);
        nrst = 1'b1; bus_if.bus_busy = 1'b0; pc = 32'h0;
        #1;
        chk("post_rst_read", {31'd0, bus_if.bus_read}, 32'd1);
        chk("post_rst_addr", bus_if.bus_addr, 32'd0);

        // Drop en during EXEC of a load: it finishes, then the unit idles.
        run_vec(vecs[4], 3);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk_idle_bus("halt");
            chk("halt_ihit", {31'd0, i_hit}, 32'd0);
            @(negedge clk);
        end
        en = 1'b1; pc = 32'h44;
        #1;
        chk("resume_read", {31'd0, bus_if.bus_read}, 32'd1);
        chk("resume_addr", bus_if.bus_addr, 32'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
